// File: rtl/usb_pkg.sv
// Shared definitions for the USB IN endpoint scheduler: PID bytes, FSM states, packet limits.
package usb_pkg;

    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    localparam int MAX_PKT = 64;

    // HS_ONLY carries the single-byte NAK/STALL response; PID opens a data packet.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_HS_ONLY,
        ST_DATA,
        ST_WAIT_HS
    } state_t;

    function automatic logic [7:0] data_pid(input logic tgl);
        return tgl ? PID_DATA1 : PID_DATA0;
    endfunction

endpackage

// File: rtl/usb_ep_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle flops; a clear in the same cycle as a flip wins.
module usb_ep_toggle_bank #(
    parameter int NUM_EP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_EP-1:0] flip,
    input  logic [NUM_EP-1:0] clr,
    output logic [NUM_EP-1:0] tgl
);

    // NOTE: reset is sampled inside the clocked block (synchronous) and all state uses <=.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tgl <= '0;
        end else begin
            tgl <= (tgl ^ flip) & ~clr;
        end
    end

endmodule

// File: rtl/usb_in_ep_scheduler.sv
// Device-side IN transaction scheduler: picks DATA/NAK/STALL, drives the shared TX byte path.
// Optional handshake timeout is built only when USB_IN_HS_TIMEOUT_EN is defined.
module usb_in_ep_scheduler
    import usb_pkg::*;
#(
    parameter int NUM_EP = 4,
    parameter int LEN_W  = 7
`ifdef USB_IN_HS_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tok_valid,
    input  logic [3:0]              tok_ep,
    output logic                    tok_ready,
    input  logic [NUM_EP-1:0]       ep_rdy,
    input  logic [NUM_EP-1:0]       ep_stall,
    input  logic [NUM_EP*LEN_W-1:0] ep_len,
    input  logic [NUM_EP*8-1:0]     ep_rd_data,
    output logic [NUM_EP-1:0]       ep_rd_en,
    output logic [NUM_EP-1:0]       ep_rewind,
    output logic [NUM_EP-1:0]       ep_done,
    input  logic [NUM_EP-1:0]       ep_tgl_clr,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_last,
    input  logic                    tx_ready,
    input  logic                    hs_valid,
    input  logic                    hs_ack,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int EP_W = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

    state_t           state, state_nx;
    logic [EP_W-1:0]  ep_q, ep_nx;
    logic [7:0]       pid_q, pid_nx;
    logic [LEN_W-1:0] cnt_q, cnt_nx;

    logic [NUM_EP-1:0] tgl, tgl_flip;
    logic [EP_W-1:0]   tok_idx;
    logic              tok_in_range;
    logic              hs_expired;

    logic [7:0]       rd_byte [NUM_EP];
    logic [LEN_W-1:0] len_arr [NUM_EP];

    assign tok_idx      = tok_ep[EP_W-1:0];
    assign tok_in_range = int'(tok_ep) < NUM_EP;
    assign tok_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);

    always_comb begin
        for (int i = 0; i < NUM_EP; i++) begin
            rd_byte[i] = ep_rd_data[i*8 +: 8];
            len_arr[i] = ep_len[i*LEN_W +: LEN_W];
        end
    end

    usb_ep_toggle_bank #(.NUM_EP(NUM_EP)) u_toggle (
        .clk  (clk),
        .rst  (rst),
        .flip (tgl_flip),
        .clr  (ep_tgl_clr),
        .tgl  (tgl)
    );

`ifdef USB_IN_HS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;

    // Counts cycles spent in WAIT_HS; expiry lands on the TIMEOUT-th such cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state == ST_WAIT_HS && !hs_valid) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign hs_expired = (to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign hs_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            ep_q  <= '0;
            pid_q <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nx;
            ep_q  <= ep_nx;
            pid_q <= pid_nx;
            cnt_q <= cnt_nx;
        end
    end

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_nx    = state;
        ep_nx       = ep_q;
        pid_nx      = pid_q;
        cnt_nx      = cnt_q;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        tx_last     = 1'b0;
        ep_rd_en    = '0;
        ep_rewind   = '0;
        ep_done     = '0;
        tgl_flip    = '0;
        err_timeout = 1'b0;

        case (state)
            ST_IDLE: begin
                if (tok_valid) begin
                    ep_nx  = tok_idx;
                    cnt_nx = '0;
                    if (!tok_in_range) begin
                        pid_nx   = PID_STALL;
                        state_nx = ST_HS_ONLY;
                    end else if (ep_stall[tok_idx]) begin
                        pid_nx   = PID_STALL;
                        state_nx = ST_HS_ONLY;
                    end else if (!ep_rdy[tok_idx]) begin
                        pid_nx   = PID_NAK;
                        state_nx = ST_HS_ONLY;
                    end else begin
                        pid_nx   = data_pid(tgl[tok_idx]);
                        cnt_nx   = len_arr[tok_idx];
                        state_nx = ST_PID;
                    end
                end
            end

            ST_HS_ONLY: begin
                tx_valid = 1'b1;
                tx_data  = pid_q;
                tx_last  = 1'b1;
                if (tx_ready) state_nx = ST_IDLE;
            end

            ST_PID: begin
                tx_valid = 1'b1;
                tx_data  = pid_q;
                tx_last  = (cnt_q == '0);
                if (tx_ready) state_nx = (cnt_q == '0) ? ST_WAIT_HS : ST_DATA;
            end

            ST_DATA: begin
                tx_valid = 1'b1;
                tx_data  = rd_byte[ep_q];
                tx_last  = (cnt_q == LEN_W'(1));
                if (tx_ready) begin
                    ep_rd_en[ep_q] = 1'b1;
                    cnt_nx         = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) state_nx = ST_WAIT_HS;
                end
            end

            ST_WAIT_HS: begin
                if (hs_valid) begin
                    if (hs_ack) begin
                        tgl_flip[ep_q] = 1'b1;
                        ep_done[ep_q]  = 1'b1;
                    end else begin
                        ep_rewind[ep_q] = 1'b1;
                    end
                    state_nx = ST_IDLE;
                end else if (hs_expired) begin
                    ep_rewind[ep_q] = 1'b1;
                    err_timeout     = 1'b1;
                    state_nx        = ST_IDLE;
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
